// File: rtl/counter_xn.sv
// counter_xn: N_CH independent prescaled down-counters with one-shot/periodic/square modes and W1C interrupts.
module counter_xn #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] cnt_out,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);
  logic [2:0] ch;
  logic [1:0] sel;
  logic [7:0][31:0] rd_ch;
  assign ch  = addr[4:2];
  assign sel = addr[1:0];
  genvar g;
  for (g = 0; g < 8; g++) begin : g_ch
    if (g < N_CH) begin : g_on
      logic [CNT_W-1:0] load, count;
      logic [PRE_W-1:0] presc, pcnt;
      logic [1:0]       mode;
      logic             en, ie, flag, out, hit, tick, expire;
      assign hit = we && ch == 3'(g);
      // a CTRL or COUNT write restarts the prescaler, so it swallows any tick of that edge
      assign tick   = en && pcnt == presc && !(hit && (sel == 2'd1 || sel == 2'd2));
      assign expire = tick && count <= CNT_W'(1) && mode != 2'd3;
      always_ff @(posedge clk) begin
        if (rst) begin
          load  <= '0;
          count <= '0;
          presc <= '0;
          pcnt  <= '0;
          mode  <= '0;
          en    <= 1'b0;
          ie    <= 1'b0;
          flag  <= 1'b0;
          out   <= 1'b0;
        end else begin
          if (en) pcnt <= pcnt == presc ? '0 : pcnt + 1'b1;
          if (mode == 2'd1) out <= 1'b0;
          if (tick && count > CNT_W'(1)) count <= count - 1'b1;
          if (expire) begin
            flag  <= 1'b1;
            out   <= mode == 2'd2 ? !out : 1'b1;
            count <= mode == 2'd0 ? '0 : load;
            if (mode == 2'd0) en <= 1'b0;
          end
          if (hit) begin
            case (sel)
              2'd0: begin
                load <= wdata[CNT_W-1:0];
                if (!en) count <= wdata[CNT_W-1:0];
              end
              2'd1: begin
                en    <= wdata[0];
                mode  <= wdata[2:1];
                ie    <= wdata[3];
                presc <= wdata[PRE_W+7:8];
                pcnt  <= '0;
                if (wdata[2:1] != mode || mode == 2'd0) out <= 1'b0;
              end
              2'd2: begin
                count <= wdata[CNT_W-1:0];
                pcnt  <= '0;
                if (mode == 2'd0) out <= 1'b0;
              end
              default: if (wdata[0] && !expire) flag <= 1'b0;
            endcase
          end
        end
      end
      assign rd_ch[g] = sel == 2'd0 ? 32'(load) :
                        sel == 2'd1 ? 32'({presc, 4'b0, ie, mode, en}) :
                        sel == 2'd2 ? 32'(count) : {30'b0, out, flag};
      assign cnt_out[g] = out;
      assign irq[g]     = flag & ie;
    end else begin : g_off
      assign rd_ch[g] = '0;
    end
  end
  assign rdata   = rd_ch[ch];
  assign irq_any = |irq;
endmodule

// File: tb/tb_counter_xn.sv
// tb_counter_xn: directed scenarios plus randomized register traffic against a per-channel behavioural model.
module tb_counter_xn;
  localparam int N_CH = 4;
  logic clk = 0, rst = 1, we = 0;
  logic [4:0] addr = '0;
  logic [31:0] wdata = '0, rdata, v;
  logic [N_CH-1:0] cnt_out, irq;
  logic irq_any;
  int n_vec = 0, n_err = 0;

  counter_xn dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
                  .rdata(rdata), .cnt_out(cnt_out), .irq(irq), .irq_any(irq_any));

  always #5 clk = ~clk;

  bit [31:0] m_load[N_CH], m_count[N_CH];
  bit [7:0] m_presc[N_CH], m_pcnt[N_CH];
  bit [1:0] m_mode[N_CH];
  bit m_en[N_CH], m_ie[N_CH], m_flag[N_CH], m_out[N_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit [31:0] m_read(input bit [4:0] a);
    int i = int'(a[4:2]);
    if (i >= N_CH) return 0;
    case (a[1:0])
      2'd0: return m_load[i];
      2'd1: return {16'b0, m_presc[i], 4'b0, m_ie[i], m_mode[i], m_en[i]};
      2'd2: return m_count[i];
      default: return {30'b0, m_out[i], m_flag[i]};
    endcase
  endfunction

  function automatic bit [N_CH-1:0] m_outs();
    for (int i = 0; i < N_CH; i++) m_outs[i] = m_out[i];
  endfunction

  function automatic bit [N_CH-1:0] m_irqs();
    for (int i = 0; i < N_CH; i++) m_irqs[i] = m_flag[i] && m_ie[i];
  endfunction

  // next state of every channel after one rising edge
  task automatic model_step(input bit r, input bit w, input bit [4:0] a, input bit [31:0] d);
    bit wr, tick, expired, old_en;
    bit [1:0] old_mode;
    for (int i = 0; i < N_CH; i++) begin
      if (r) begin
        m_load[i] = 0; m_count[i] = 0; m_presc[i] = 0; m_pcnt[i] = 0; m_mode[i] = 0;
        m_en[i] = 0; m_ie[i] = 0; m_flag[i] = 0; m_out[i] = 0;
        continue;
      end
      wr = w && int'(a[4:2]) == i;
      old_en = m_en[i];
      old_mode = m_mode[i];
      tick = old_en && m_pcnt[i] == m_presc[i] && !(wr && (a[1:0] == 1 || a[1:0] == 2));
      expired = tick && m_count[i] <= 1 && old_mode != 3;
      if (old_en) m_pcnt[i] = (m_pcnt[i] == m_presc[i]) ? 8'd0 : m_pcnt[i] + 8'd1;
      if (old_mode == 1) m_out[i] = 0;
      if (tick && m_count[i] > 1) m_count[i] = m_count[i] - 1;
      else if (expired) begin
        m_flag[i] = 1;
        if (old_mode == 0) begin m_count[i] = 0; m_en[i] = 0; m_out[i] = 1; end
        else if (old_mode == 1) begin m_count[i] = m_load[i]; m_out[i] = 1; end
        else begin m_count[i] = m_load[i]; m_out[i] = !m_out[i]; end
      end
      if (wr) begin
        if (a[1:0] == 0) begin
          m_load[i] = d;
          if (!old_en) m_count[i] = d;
        end else if (a[1:0] == 1) begin
          if (d[2:1] != old_mode || old_mode == 0) m_out[i] = 0;
          m_en[i] = d[0]; m_mode[i] = d[2:1]; m_ie[i] = d[3]; m_presc[i] = d[15:8]; m_pcnt[i] = 0;
        end else if (a[1:0] == 2) begin
          m_count[i] = d; m_pcnt[i] = 0;
          if (old_mode == 0) m_out[i] = 0;
        end else if (d[0] && !expired) m_flag[i] = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit w, input bit [4:0] a, input bit [31:0] d);
    rst = r; we = w; addr = a; wdata = d;
    #1;
    chk("rdata", rdata, m_read(a));
    chk("cnt_out", 32'(cnt_out), 32'(m_outs()));
    chk("irq", 32'(irq), 32'(m_irqs()));
    chk("irq_any", 32'(irq_any), 32'(|m_irqs()));
    @(posedge clk);
    model_step(r, w, a, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 5'd0, 0);
  endtask

  task automatic peek(input bit [4:0] a, output logic [31:0] q);
    rst = 0; we = 0; addr = a;
    #1;
    q = rdata;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_step(1, 0, 0, 0);
    @(negedge clk);
    cycle(1, 0, 5'd0, 0);
    for (int i = 0; i < N_CH; i++) begin
      peek({3'(i), 2'd2}, v); chk("rst_count", v, 0);
      peek({3'(i), 2'd1}, v); chk("rst_ctrl", v, 0);
    end
    // one-shot on ch0: LOAD=3, en/mode0/ie, presc 0
    cycle(0, 1, {3'd0, 2'd0}, 3);
    cycle(0, 1, {3'd0, 2'd1}, 32'h9);
    idle(1); peek({3'd0, 2'd2}, v); chk("os_cnt2", v, 2);
    idle(1); peek({3'd0, 2'd2}, v); chk("os_cnt1", v, 1);
    chk("os_noirq", 32'(irq_any), 0);
    idle(1); peek({3'd0, 2'd2}, v); chk("os_cnt0", v, 0);
    chk("os_irq0", 32'(irq[0]), 1);
    chk("os_irq_any", 32'(irq_any), 1);
    chk("os_out0", 32'(cnt_out[0]), 1);
    peek({3'd0, 2'd1}, v); chk("os_en_off", v, 32'h8);
    peek({3'd0, 2'd3}, v); chk("os_status", v, 3);
    idle(3); chk("os_out_held", 32'(cnt_out[0]), 1);
    cycle(0, 1, {3'd0, 2'd3}, 1);
    cycle(0, 1, {3'd0, 2'd1}, 0);
    chk("os_out_clr", 32'(cnt_out[0]), 0);
    // COUNT write coincident with expiry wins
    cycle(0, 1, {3'd0, 2'd0}, 3);
    cycle(0, 1, {3'd0, 2'd1}, 32'hB);
    idle(2);
    cycle(0, 1, {3'd0, 2'd2}, 100);
    peek({3'd0, 2'd2}, v); chk("prio_count", v, 100);
    cycle(0, 1, {3'd0, 2'd1}, 0);
    // out-of-range channel
    cycle(0, 1, {3'd5, 2'd0}, 32'h55);
    peek({3'd5, 2'd0}, v); chk("oor_load", v, 0);
    peek({3'd5, 2'd2}, v); chk("oor_count", v, 0);
    // periodic ch1, presc 2, W1C coincident with expiry
    cycle(0, 1, {3'd1, 2'd0}, 4);
    cycle(0, 1, {3'd1, 2'd1}, 32'h20B);
    idle(11);
    chk("per_pre_out", 32'(cnt_out[1]), 0);
    cycle(0, 1, {3'd1, 2'd3}, 1);
    chk("per_pulse", 32'(cnt_out[1]), 1);
    peek({3'd1, 2'd3}, v); chk("per_w1c_lose", v, 3);
    peek({3'd1, 2'd2}, v); chk("per_reload", v, 4);
    cycle(0, 1, {3'd1, 2'd3}, 1);
    chk("per_pulse_end", 32'(cnt_out[1]), 0);
    peek({3'd1, 2'd3}, v); chk("per_w1c", v, 0);
    // square on all channels then mid-run reset
    for (int i = 0; i < N_CH; i++) begin
      cycle(0, 1, {3'(i), 2'd0}, 5);
      cycle(0, 1, {3'(i), 2'd1}, 32'hD);
    end
    idle(7);
    cycle(1, 1, {3'd0, 2'd1}, 32'h9);
    chk("rst_irq_any", 32'(irq_any), 0);
    chk("rst_cnt_out", 32'(cnt_out), 0);
    idle(5);
    for (int i = 0; i < N_CH; i++) begin
      peek({3'(i), 2'd2}, v); chk("rst_frozen", v, 0);
    end
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] a;
      bit [31:0] d;
      a = 5'($urandom);
      case (a[1:0])
        2'd0: d = $urandom_range(0, 6);
        2'd1: d = ($urandom_range(0, 3) << 8) | ($urandom & 32'hF7) | 32'(($urandom % 4) != 0);
        2'd2: d = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 7);
        default: d = $urandom;
      endcase
      cycle($urandom % 200 == 0, $urandom % 3 == 0, a, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/counter_xn.md
COUNTER_XN -- requirements
Module: counter_xn

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent counter channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/load width in bits (8..32).
REQ-003 SHALL have parameter PRE_W, default 8, prescaler width in bits (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port we  input  1  register write strobe, one write per asserted cycle.
REQ-007 SHALL have port addr  input  5  {ch[2:0], sel[1:0]}; sel 0=LOAD, 1=CTRL, 2=COUNT, 3=STATUS.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  combinational read of the addressed register, zero-extended.
REQ-010 SHALL have port cnt_out  output  N_CH  per-channel waveform output (registered).
REQ-011 SHALL have port irq  output  N_CH  per-channel interrupt, irq[i] = flag[i] & ie[i].
REQ-012 SHALL have port irq_any  output  1  OR of all irq bits.

Function
REQ-013 SHALL hold, per channel: LOAD[CNT_W], COUNT[CNT_W], CTRL {en bit0, mode bits2:1, ie bit3, presc bits PRE_W+7:8}, prescaler counter PRE_W bits, flag, out.
REQ-014 SHALL ignore writes and read 0 when ch >= N_CH.
REQ-015 SHALL, on write to LOAD, store wdata[CNT_W-1:0]; if channel en=0, also copy it into COUNT the same edge.
REQ-016 SHALL, on write to COUNT, store wdata directly into COUNT and clear the prescaler counter; this write takes priority over any decrement/reload in the same cycle.
REQ-017 SHALL, on write to CTRL, update en/mode/ie/presc and clear the prescaler counter.
REQ-018 SHALL, on write to STATUS with wdata[0]=1, clear flag; a flag-set event in the same cycle wins (flag stays 1).
REQ-019 SHALL read STATUS as {30'b0, out, flag}; CTRL/LOAD/COUNT read back as stored.
REQ-020 SHALL generate a tick when en=1 and prescaler counter == presc (then counter returns to 0), else increment prescaler; tick period = presc+1 cycles; en=0 freezes prescaler and COUNT.
REQ-021 SHALL, on tick with COUNT > 1, decrement COUNT by 1.
REQ-022 SHALL, on tick with COUNT <= 1 (expiry), set flag and act per mode:
 - mode 0 one-shot: COUNT<=0, en<=0, out<=1 (held until COUNT or CTRL write clears out).
 - mode 1 periodic: COUNT<=LOAD, out pulses 1 for exactly one cycle.
 - mode 2 square: COUNT<=LOAD, out toggles.
 - mode 3 reserved: no COUNT, flag or out change.
REQ-023 SHALL treat LOAD=0 or 1 in modes 1/2 as expiry on every tick (COUNT stays at LOAD).
REQ-024 SHALL clear out on any CTRL write that changes mode.
REQ-025 SHALL make a LOAD write while en=1 take effect only at the next reload.
REQ-026 SHALL keep channels fully independent; simultaneous expiries on multiple channels all set their flags in the same cycle.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, clear LOAD, COUNT, CTRL, prescaler, flag and out of every channel; irq=0, irq_any=0, cnt_out=0 the following cycle.
REQ-028 SHALL abort any in-progress count on reset with no residual flag or out pulse; writes in reset cycles are ignored.

Verification
REQ-029 One-shot: ch0 LOAD=3, CTRL en=1 mode0 ie=1 presc=0 at cycle t -> COUNT 2,1,0 at t+1..t+3; flag, irq[0], irq_any, cnt_out[0]=1 from t+3; en reads 0.
REQ-030 Periodic with prescale: ch1 LOAD=4, presc=2, mode1 -> cnt_out[1] one-cycle pulse every 12 cycles, COUNT reloads 4; STATUS W1C clears flag; W1C coincident with expiry -> flag remains 1.
REQ-031 Square: ch2 LOAD=5, presc=0, mode2 -> cnt_out[2] toggles every 5 cycles (period 10); LOAD=2 written mid-run -> new half-period 2 starting after current reload.
REQ-032 Priority: COUNT write of 100 in the same cycle as ch0 expiry -> COUNT=100, no reload; write to ch index 5 with N_CH=4 -> no state change, rdata=0.
REQ-033 Reset mid-run: all four channels running, rst=1 for one cycle -> every register, irq, irq_any, cnt_out = 0 next cycle; no tick until CTRL rewritten.
